forward_hazard_unit: RTL
========================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 4: register-address width in bits.
REQ-002 SHALL have parameter NSRC, default 2: number of source operands per instruction.
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width in bits.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port CLK, input, 1: clock, rising edge.
REQ-006 SHALL have port RST_N, input, 1: synchronous active-low reset.
REQ-007 SHALL have port ID_VALID, input, 1: decode-stage instruction present.
REQ-008 SHALL have port ID_SRC, input, NSRC*REG_AW: source register i at [i*REG_AW +: REG_AW].
REQ-009 SHALL have port ID_SRC_USE, input, NSRC: bit i set means source i is read.
REQ-010 SHALL have port ID_DST, input, REG_AW: destination register.
REQ-011 SHALL have port ID_WB, input, 1: instruction writes back.
REQ-012 SHALL have port ID_LOAD, input, 1: instruction is a load.
REQ-013 SHALL have port FLUSH, input, 1: discard the decode-stage instruction this cycle.
REQ-014 SHALL have port FM, output, 2*NSRC: forward select for EX source i at [2i+1:2i]; 00 = regfile, 01 = MEM_WB, 10 = EXE_MEM.
REQ-015 SHALL have port STALL, output, 1: hold fetch/decode this cycle.
REQ-016 SHALL have port STALL_CNT, output, CNT_W: count of stall cycles.

Function
REQ-017 SHALL hold three internal slots: EX {valid, src[], src_use[], dst, wb, load}, MEM {valid, dst, wb, load}, WB {valid, dst, wb}.
REQ-018 SHALL advance every clock: WB<=MEM, MEM<=EX, EX<=ID fields, or a bubble (valid=0) when STALL, FLUSH or !ID_VALID.
REQ-019 SHALL drive STALL combinationally = ID_VALID & !FLUSH & EX.valid & EX.load & EX.wb & (any i: ID_SRC_USE[i] & ID_SRC[i]==EX.dst).
REQ-020 SHALL drive FM[i] combinationally from the EX slot; it is 00 unless EX.valid & EX.src_use[i].
REQ-021 SHALL select 10 when MEM.valid & MEM.wb & MEM.dst==EX.src[i]; otherwise 01 when WB.valid & WB.wb & WB.dst==EX.src[i]; otherwise 00.
REQ-022 SHALL give EXE_MEM priority over MEM_WB when both match the same source.
REQ-023 SHALL apply a load-use penalty of exactly one cycle; the consumer then reaches EX with the load in WB, so FM=01.
REQ-024 SHALL give FLUSH priority over STALL: with FLUSH=1, STALL=0 and EX receives a bubble.
REQ-025 SHALL increment STALL_CNT on each clock with STALL=1, saturating at all-ones with no wrap.
REQ-026 SHALL compare sources independently; several sources may forward in the same cycle.

Reset
REQ-027 SHALL, on a clock with RST_N=0, clear all slot valid bits and set STALL_CNT=0; in-flight state is discarded, including mid-stall.
REQ-028 SHALL give outputs after reset of FM=0, STALL=0 and STALL_CNT=0.

Configuration
REQ-029 SHALL, when macro FWD_ZERO_REG_EN is defined, never match register 0 as a destination, so there is no forward and no stall on register 0.
REQ-030 SHALL, when FWD_ZERO_REG_EN is undefined, treat register 0 like any other register.

Verification (REG_AW=4, NSRC=2)
REQ-031 SHALL cover: ALU dst=1 wb=1, then next ID src0=1 use=01 -> in the following cycle FM=2'b10 (FM[1:0]=10).
REQ-032 SHALL cover: dst=1 wb=1, then a bubble, then src1=1 use=10 -> consumer in EX shows FM=4'b0100.
REQ-033 SHALL cover: dst=3 and then dst=3 again, both wb=1, then src0=3 -> FM[1:0]=10 (priority).
REQ-034 SHALL cover: load dst=2, then src0=2 -> STALL=1 for one cycle, STALL_CNT 0->1, then FM[1:0]=01 with no second stall.
REQ-035 SHALL cover: producer dst=5 wb=0, then consumer src0=5 -> FM=0, STALL=0.
REQ-036 SHALL cover: with FWD_ZERO_REG_EN, load dst=0 then src0=0 -> STALL=0, FM=0; and RST_N=0 during a pending forward -> next cycle FM=0, STALL_CNT=0.

Source files
------------

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: operand-forwarding selects and load-use stall detection
// for a pipeline with EX, MEM and WB stages, plus a saturating stall counter.
// Optional build macro FWD_ZERO_REG_EN: register 0 is hard-wired, so it never
// counts as a destination (no forward from it and no stall on it).
module forward_hazard_unit #(
  parameter int REG_AW = 4,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     ID_VALID,
  input  logic [NSRC*REG_AW-1:0]   ID_SRC,
  input  logic [NSRC-1:0]          ID_SRC_USE,
  input  logic [REG_AW-1:0]        ID_DST,
  input  logic                     ID_WB,
  input  logic                     ID_LOAD,
  input  logic                     FLUSH,
  output logic [2*NSRC-1:0]        FM,
  output logic                     STALL,
  output logic [CNT_W-1:0]         STALL_CNT
);

  // EX slot keeps everything needed to drive forwarding and stall decisions.
  logic                   ex_valid;
  logic [NSRC*REG_AW-1:0] ex_src;
  logic [NSRC-1:0]        ex_src_use;
  logic [REG_AW-1:0]      ex_dst;
  logic                   ex_wb;
  logic                   ex_load;

  // MEM and WB slots only need to say which register they will write; the
  // load flag has no consumer once the instruction has left EX.
  logic                   mem_valid;
  logic [REG_AW-1:0]      mem_dst;
  logic                   mem_wb;

  logic                   wb_valid;
  logic [REG_AW-1:0]      wb_dst;
  logic                   wb_wb;

  // Per-stage qualifier: may this stage's destination be matched at all?
  logic ex_dst_ok;
  logic mem_dst_ok;
  logic wb_dst_ok;

`ifdef FWD_ZERO_REG_EN
  assign ex_dst_ok  = (ex_dst  != '0);
  assign mem_dst_ok = (mem_dst != '0);
  assign wb_dst_ok  = (wb_dst  != '0);
`else
  assign ex_dst_ok  = 1'b1;
  assign mem_dst_ok = 1'b1;
  assign wb_dst_ok  = 1'b1;
`endif

  logic mem_writes;
  logic wb_writes;
  logic ex_load_writes;
  logic src_hit_ex;

  assign mem_writes     = mem_valid & mem_wb & mem_dst_ok;
  assign wb_writes      = wb_valid & wb_wb & wb_dst_ok;
  assign ex_load_writes = ex_valid & ex_load & ex_wb & ex_dst_ok;

  // Detect a decode-stage source that needs the result of the load now in EX.
  always_comb begin
    src_hit_ex = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (ID_SRC_USE[i] && (ID_SRC[i*REG_AW +: REG_AW] == ex_dst))
        src_hit_ex = 1'b1;
    end
  end

  // A flushed or absent decode instruction can never cause a stall.
  assign STALL = ID_VALID & ~FLUSH & ex_load_writes & src_hit_ex;

  // Forward select per EX source: the nearest producer (MEM) wins over WB.
  always_comb begin
    FM = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (ex_valid && ex_src_use[i]) begin
        if (mem_writes && (mem_dst == ex_src[i*REG_AW +: REG_AW]))
          FM[2*i +: 2] = 2'b10;
        else if (wb_writes && (wb_dst == ex_src[i*REG_AW +: REG_AW]))
          FM[2*i +: 2] = 2'b01;
      end
    end
  end

  // Advance the pipeline slots; a stall, flush or empty decode injects a bubble.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ex_valid  <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
    end else begin
      wb_valid   <= mem_valid;
      wb_dst     <= mem_dst;
      wb_wb      <= mem_wb;
      mem_valid  <= ex_valid;
      mem_dst    <= ex_dst;
      mem_wb     <= ex_wb;
      ex_valid   <= ID_VALID & ~FLUSH & ~STALL;
      ex_src     <= ID_SRC;
      ex_src_use <= ID_SRC_USE;
      ex_dst     <= ID_DST;
      ex_wb      <= ID_WB;
      ex_load    <= ID_LOAD;
    end
  end

  // Count stall cycles, holding at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      STALL_CNT <= '0;
    else if (STALL && (STALL_CNT != '1))
      STALL_CNT <= STALL_CNT + 1'b1;
  end

endmodule
